uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one UART transmitter (`uart_tx`) among `NREQ` byte requesters. It accepts one byte plus its frame configuration (length, parity, stop bits) from the winning requester and drives the transmitter's `tx_start`/data/config inputs. It holds them until the transmitter reports `tx_done`, then returns a per-transfer completion record. It sits between the system-side producers and the UART transmit datapath.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 200000, max `clk` cycles in XMIT before abort (used only with `UART_SCHED_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request; held with data/cfg stable until accepted
- `req_data`  in  NREQ*8  byte per requester, requester i at [8i+7:8i]
- `req_cfg`  in  NREQ*7  cfg per requester, i at [7i+6:7i]: {length[3:0], parity_en, parity_type, stop2}
- `req_ready`  out  NREQ  one-hot accept; transfer when valid&&ready at a rising edge
- `tx_start`  out  1  start request to transmitter
- `tx_data`  out  8  latched byte
- `length`  out  4  latched frame length
- `parity_en`, `parity_type`, `stop2`  out  1 each  latched frame config
- `tx_done`  in  1  transmitter done, already synchronous to `clk`
- `tx_err`  in  1  transmitter error, already synchronous to `clk`
- `done_valid`  out  1  one-cycle completion pulse
- `done_id`  out  $clog2(NREQ)  requester index of completed transfer
- `done_err`  out  1  transfer failed (tx_err, invalid length, or timeout)

## Operation
- States: IDLE, XMIT, REPORT, RELEASE.
- IDLE:
  - `req_ready` is combinational, equal to the one-hot round-robin winner among `req_valid`.
  - Search order: `ptr`, `ptr+1`, … modulo NREQ.
  - On accept: latch data/cfg and winner id, set `ptr <= (winner+1) mod NREQ`.
  - Go to XMIT if length ∈ {5,6,7,8}, else go to REPORT with err=1 and no `tx_start`.
- XMIT:
  - `tx_start=1`; outputs hold latched values.
  - `err_acc |= tx_err` each cycle.
  - On `tx_done=1` go to REPORT.
- REPORT: `done_valid=1` for exactly one cycle; `done_err = err_acc`; `tx_start=0`. Go to RELEASE.
- RELEASE: wait until `tx_done=0`, then go to IDLE. This blocks re-triggering on a stale done level.
- `req_ready` is 0 in every state except IDLE. No new accept happens until IDLE is re-entered.
- `req_valid` deasserting without acceptance is legal and has no effect.

## Timing
- Reset values: state IDLE, `ptr=0`, all outputs 0 (`req_ready` 0 because `req_valid` is ignored during reset).
- Accept at edge N → `tx_start=1` from cycle N+1.
- `tx_done` seen at edge M → `tx_start=0` and `done_valid=1` in cycle M+1.
- Invalid length accepted at N → `done_valid`/`done_err=1` at N+1; `tx_start` never asserts.
- `tx_err` and `tx_done` asserted in the same cycle → error is captured.
- Minimum spacing between accepts: 3 cycles (XMIT/REPORT/RELEASE), plus the time `tx_done` stays high.
- `rst` mid-XMIT: `tx_start` drops the next cycle; no `done_valid` is issued for the aborted transfer.

## Configuration
- `UART_SCHED_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on XMIT entry and increments each XMIT cycle.
  - When it reaches TIMEOUT without `tx_done`, go to REPORT with `done_err=1`, then RELEASE.
- Undefined: no counter is generated, XMIT waits indefinitely, and `TIMEOUT` is unused.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum `sched_state_t`
  - the packed struct `uart_cfg_t` {length, parity_en, parity_type, stop2}
  - `CFG_W=7`
  - constants `LEN_MIN=5`, `LEN_MAX=8`
- Sub-module `rr_arbiter` is purely combinational: inputs `req`, `ptr`; outputs one-hot `grant` and `grant_id`.

## Test plan
- Single request: req 2 valid, data 8'hA5, cfg {8,1,0,0} → `req_ready[2]` for 1 cycle, `tx_start` the next cycle with `tx_data`=A5, `length`=8; pulse `tx_done` → `done_valid`, `done_id`=2, `done_err`=0.
- Round robin: all 4 requesters continuously valid → acceptance order 0,1,2,3,0; `ptr` wraps after 3.
- Invalid length: cfg length=4 from req 1 → `done_err=1` one cycle after accept; `tx_start` stays 0.
- Error capture: `tx_err` pulse during XMIT, then `tx_done` → `done_err=1`; next transfer reports err=0.
- Stale done: `tx_done` held high 10 cycles → exactly one `done_valid`; no accept until `tx_done` falls.
- Reset mid-XMIT, plus timeout with `TIMEOUT=50` under `UART_SCHED_TIMEOUT_EN` and `tx_done` never asserted:
  - reset → all outputs 0, no `done_valid`, next accept goes to req 0
  - timeout → `done_err=1` 51 cycles after XMIT entry

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
// Optional timeout support in the top is selected by UART_SCHED_TIMEOUT_EN.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_XMIT    = 2'd1,
        S_REPORT  = 2'd2,
        S_RELEASE = 2'd3
    } sched_state_t;

    localparam int CFG_W = 7;
    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'd8;

    typedef struct packed {
        logic [3:0] length;
        logic       parity_en;
        logic       parity_type;
        logic       stop2;
    } uart_cfg_t;

    function automatic logic len_ok(input logic [3:0] len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request found
// searching upward from ptr (wrapping) wins; grant is one-hot.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IDW = $clog2(NREQ);

    logic w_found;
    int   w_idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                grant[w_idx]  = 1'b1;
                grant_id      = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ requesters with round-robin accept.
// Define UART_SCHED_TIMEOUT_EN to abort transfers stuck in XMIT for TIMEOUT cycles.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*8-1:0]         req_data,
    input  logic [NREQ*CFG_W-1:0]     req_cfg,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic [3:0]                length,
    output logic                      parity_en,
    output logic                      parity_type,
    output logic                      stop2,
    input  logic                      tx_done,
    input  logic                      tx_err,
    output logic                      done_valid,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic                      done_err,
    output sched_state_t              dbg_state
);
    localparam int IDW = $clog2(NREQ);

    sched_state_t   r_state, w_state_nx;
    logic [IDW-1:0] r_ptr, r_id, w_gid;
    logic [NREQ-1:0] w_grant;
    logic [7:0]     r_data, w_data;
    uart_cfg_t      r_cfg, w_cfg;
    logic           r_err, w_accept, w_len_ok, w_timeout;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req_valid),
        .ptr      (r_ptr),
        .grant    (w_grant),
        .grant_id (w_gid)
    );

    assign w_data   = req_data[int'(w_gid)*8 +: 8];
    assign w_cfg    = uart_cfg_t'(req_cfg[int'(w_gid)*CFG_W +: CFG_W]);
    assign w_len_ok = len_ok(w_cfg.length);

    // Valid/ready: a requester holds valid with stable data/cfg; the transfer
    // happens at the rising edge where valid && ready. Ready only in IDLE, never in reset.
    assign req_ready = (r_state == S_IDLE && !rst) ? w_grant : '0;
    assign w_accept  = |req_ready;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (rst || r_state != S_XMIT) r_tcnt <= '0;
        else                          r_tcnt <= r_tcnt + TW'(1);
    end

    assign w_timeout = (r_state == S_XMIT) && (r_tcnt == TW'(TIMEOUT));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nx = w_len_ok ? S_XMIT : S_REPORT;
            S_XMIT:    if (tx_done || w_timeout) w_state_nx = S_REPORT;
            S_REPORT:  w_state_nx = S_RELEASE;
            // A done level left high from this transfer must not end the next one.
            S_RELEASE: if (!tx_done) w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_data <= '0;
            r_cfg  <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_data;
            r_cfg  <= w_cfg;
            r_id   <= w_gid;
            r_ptr  <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
            r_err  <= !w_len_ok;
        end else if (r_state == S_XMIT) begin
            r_err  <= r_err | tx_err | w_timeout;
        end
    end

    assign tx_start    = (r_state == S_XMIT);
    assign tx_data     = r_data;
    assign length      = r_cfg.length;
    assign parity_en   = r_cfg.parity_en;
    assign parity_type = r_cfg.parity_type;
    assign stop2       = r_cfg.stop2;
    assign done_valid  = (r_state == S_REPORT);
    assign done_id     = done_valid ? r_id : '0;
    assign done_err    = done_valid & r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched; the driver predicts winners
// and completion records, an independent monitor checks each done pulse.
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int REC_W = 18;
`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 200000;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ*7-1:0] req_cfg = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [3:0]        length;
    logic              parity_en, parity_type, stop2;
    logic              tx_done = 1'b0;
    logic              tx_err = 1'b0;
    logic              done_valid;
    logic [1:0]        done_id;
    logic              done_err;
    sched_state_t      dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int n_push   = 0;
    int n_done   = 0;
    int m_ptr    = 0;
    logic [REC_W-1:0] exp_q[$];

    uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_cfg(req_cfg),
        .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .length(length),
        .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
        .tx_done(tx_done), .tx_err(tx_err),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference arbitration: first requester in the set, scanning from ptr with wrap.
    function automatic int rr_pick(input logic [NREQ-1:0] set, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (set[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding record.
    initial begin
        logic [REC_W-1:0] e;
        forever begin
            @(negedge clk);
            if (done_valid) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done_id), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("done_record",
                          32'({done_id, done_err, tx_data, length, parity_en, parity_type, stop2}),
                          32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1);
    end

    // Drives a request set, waits for the predicted winner, pushes its record.
    task automatic accept_one(input logic [NREQ-1:0] set, input logic [NREQ*8-1:0] dat,
                              input logic [NREQ*7-1:0] cfg, input bit force_err,
                              output int win, output bit len_valid);
        logic [3:0] len;
        logic [3:0] exp_gnt;
        int cyc;
        win       = rr_pick(set, m_ptr);
        len       = cfg[7*win+3 +: 4];
        len_valid = (len >= 4'd5) && (len <= 4'd8);
        exp_gnt   = 4'b0001 << win;
        req_data  = dat;
        req_cfg   = cfg;
        req_valid = set;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("ready_onehot", 32'(req_ready), 32'(exp_gnt));
        exp_q.push_back({2'(win), (!len_valid || force_err), dat[8*win +: 8], cfg[7*win +: 7]});
        n_push++;
        m_ptr = (win + 1) % NREQ;
    endtask

    // err_mode: 0 none, 1 tx_err pulse before done, 2 tx_err together with done.
    task automatic do_xfer(input logic [NREQ-1:0] set, input logic [NREQ*8-1:0] dat,
                           input logic [NREQ*7-1:0] cfg, input int err_mode,
                           input int delay, input int hold, input bit keep);
        int win;
        bit len_valid;
        accept_one(set, dat, cfg, err_mode != 0, win, len_valid);
        @(negedge clk);
        if (!len_valid) begin
            check("inv_no_start", 32'(tx_start), 32'd0);
            check("inv_done_next", 32'(done_valid), 32'd1);
            if (!keep) req_valid = '0;
            return;
        end
        check("start_after_accept", 32'(tx_start), 32'd1);
        check("tx_data_latched", 32'({tx_data, length}), 32'({dat[8*win +: 8], cfg[7*win+3 +: 4]}));
        if (!keep) req_valid = '0;
        repeat (delay) @(negedge clk);
        if (err_mode == 1) begin
            tx_err = 1'b1;
            @(negedge clk);
            tx_err = 1'b0;
        end
        tx_done = 1'b1;
        if (err_mode == 2) tx_err = 1'b1;
        @(negedge clk);
        check("start_drop_on_done", 32'(tx_start), 32'd0);
        check("done_after_tx_done", 32'(done_valid), 32'd1);
        tx_err = 1'b0;
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            if (keep) check("no_accept_while_done", 32'(req_ready), 32'd0);
        end
        tx_done = 1'b0;
    endtask

    initial begin
        logic [NREQ*8-1:0] dat;
        logic [NREQ*7-1:0] cfg;
        int  win;
        bit  lv;
        int  cyc;

        // Reset with requests present: nothing may be granted.
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_outputs", 32'({tx_start, tx_data, length, parity_en, parity_type, stop2,
                                     done_valid, done_id, done_err}), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2, byte A5, 8 bits with parity enabled.
        dat = '0; dat[23:16] = 8'hA5;
        cfg = '0; cfg[20:14] = {4'd8, 1'b1, 1'b0, 1'b0};
        do_xfer(4'b0100, dat, cfg, 0, 2, 1, 1'b0);

        // Invalid length from requester 1.
        cfg = '0; cfg[13:7] = {4'd4, 3'b000};
        do_xfer(4'b0010, 32'h00C300, cfg, 0, 0, 1, 1'b0);

        // Error captured mid-transfer, then a clean transfer.
        cfg = {4{4'd7, 3'b010}};
        do_xfer(4'b0001, 32'h0000005A, cfg, 1, 1, 1, 1'b0);
        do_xfer(4'b0001, 32'h0000003C, cfg, 0, 0, 2, 1'b0);
        do_xfer(4'b1000, 32'h77000000, cfg, 2, 3, 1, 1'b0);

        // Reset in the middle of XMIT: aborted transfer never reports.
        cfg = {4{4'd8, 3'b001}};
        accept_one(4'b1000, 32'h11223344, cfg, 1'b0, win, lv);
        @(negedge clk);
        check("rst_pre_start", 32'(tx_start), 32'd1);
        req_valid = 4'hF;
        rst = 1'b1;
        void'(exp_q.pop_back());
        n_push--;
        @(negedge clk);
        #1;
        check("rst_mid_start", 32'(tx_start), 32'd0);
        check("rst_mid_outputs", 32'({req_ready, tx_data, length, done_valid, done_err}), 32'd0);
        rst = 1'b0;
        m_ptr = 0;
        req_valid = '0;
        @(negedge clk);

        // Round robin with every requester continuously valid: 0,1,2,3,0.
        dat = 32'hD4C3B2A1;
        cfg = {4'd5, 3'b111, 4'd6, 3'b110, 4'd7, 3'b101, 4'd8, 3'b100};
        for (int t = 0; t < 5; t++) do_xfer(4'hF, dat, cfg, 0, t % 3, 1, 1'b1);

        // Stale done held for 10 cycles: one completion, no accept meanwhile.
        do_xfer(4'hF, dat, cfg, 0, 1, 10, 1'b1);
        req_valid = '0;
        @(negedge clk);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            dat = $urandom;
            for (int i = 0; i < NREQ; i++)
                cfg[7*i +: 7] = {4'($urandom_range(3, 9)), 3'($urandom_range(0, 7))};
            do_xfer(4'($urandom_range(1, 15)), dat, cfg, $urandom_range(0, 2),
                    $urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            req_valid = '0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef UART_SCHED_TIMEOUT_EN
        // Transmitter never finishes: the transfer aborts with an error.
        @(negedge clk);
        cfg = {4{4'd8, 3'b000}};
        accept_one(4'b0001, 32'h000000E7, cfg, 1'b1, win, lv);
        @(negedge clk);
        req_valid = '0;
        cyc = 0;
        while (!done_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_latency", 32'(cyc), 32'd51);
`else
        cyc = 0;
`endif

        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_push));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
